// File: rtl/audio_spi_pkg.sv
// ---------------------------------------------------------------------------
// audio_spi_pkg
// Shared constants for the audio SPI transmitter: word width, default
// timing parameters and the serialiser FSM state codes.
// No ports.
// ---------------------------------------------------------------------------
package audio_spi_pkg;

   localparam int WORD_W         = 16;
   localparam int DEF_SCLK_DIV   = 4;
   localparam int DEF_CS_GAP     = 8;
   localparam int DEF_FIFO_DEPTH = 4;

   // Serialiser FSM state codes
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/spi_tx_fifo.sv
// ---------------------------------------------------------------------------
// spi_tx_fifo
// Single-clock synchronous word FIFO with a registered fill level.
// Ports:
//   clk        in   system clock (rising edge)
//   reset      in   asynchronous active-high reset, empties the FIFO
//   push       in   write request; ignored while full
//   push_data  in   word to write
//   pop        in   read request; ignored while empty
//   pop_data   out  word at the head of the FIFO (valid when !empty)
//   level      out  number of words held
//   full       out  level == DEPTH (registered state only)
//   empty      out  level == 0
// ---------------------------------------------------------------------------
module spi_tx_fifo
   import audio_spi_pkg::*;
#(
   parameter int W     = WORD_W,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             pop_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("spi_tx_fifo: DEPTH must be a power of 2 and at least 2");
      end
   endgenerate

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level_q;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (level_q == LVL_W'(DEPTH));
   assign empty    = (level_q == '0);
   assign level    = level_q;
   assign pop_data = mem[rd_ptr];
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;

   // Pointers are exactly PTR_W bits wide, so increments wrap modulo DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/audio_spi_tx.sv
// ---------------------------------------------------------------------------
// audio_spi_tx
// Buffers 16-bit audio samples in a small FIFO and sends each one as an
// SPI-style frame (mode 0, MSB first) to the Pico receiver.
// Ports:
//   clk_25mhz       in   system clock (rising edge)
//   reset           in   asynchronous active-high reset, aborts any frame
//   audio_in        in   sample word
//   audio_valid     in   audio_in presented this cycle
//   audio_ready     out  FIFO not full; word taken when valid && ready
//   com_sclk_out    out  serial clock, idle low
//   com_mosi_out    out  serial data, MSB first, changes on SCLK fall
//   com_active_out  out  frame select, active low
//   busy            out  high from frame start to the end of the CS gap
//   fifo_level      out  words held in the FIFO
//   fsm_state       out  current serialiser state code (debug)
// Handshake: a word is transferred on every rising clk_25mhz edge where
// audio_valid && audio_ready; audio_ready depends on registered state only,
// and audio_valid may be held while waiting.
// ---------------------------------------------------------------------------
module audio_spi_tx
   import audio_spi_pkg::*;
#(
   parameter int SCLK_DIV   = DEF_SCLK_DIV,
   parameter int CS_GAP     = DEF_CS_GAP,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                         clk_25mhz,
   input  logic                         reset,
   input  logic [WORD_W-1:0]            audio_in,
   input  logic                         audio_valid,
   output logic                         audio_ready,
   output logic                         com_sclk_out,
   output logic                         com_mosi_out,
   output logic                         com_active_out,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic [2:0]                   fsm_state
);

   // The receiver synchronises SCLK through two flops, so a half period
   // must span at least three system clocks.
   generate
      if (SCLK_DIV < 3) begin : g_bad_div
         $error("audio_spi_tx: SCLK_DIV must be >= 3");
      end
      if (CS_GAP < 2) begin : g_bad_gap
         $error("audio_spi_tx: CS_GAP must be >= 2");
      end
   endgenerate

   // One counter serves both the SCLK half-period and the CS gap.
   localparam int CNT_MAX = (SCLK_DIV > CS_GAP) ? SCLK_DIV : CS_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SCLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
   localparam logic [4:0]       BITS_LAST = 5'(WORD_W);

   logic [2:0]        state_q,  state_d;
   logic [CNT_W-1:0]  div_q,    div_d;
   logic [4:0]        bit_q,    bit_d;
   logic [WORD_W-1:0] shreg_q,  shreg_d;
   logic              sclk_q,   sclk_d;
   logic              active_q, active_d;

   logic              fifo_pop;
   logic [WORD_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;

   spi_tx_fifo #(
      .W     (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_25mhz),
      .reset     (reset),
      .push      (audio_valid),
      .push_data (audio_in),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         div_q    <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         sclk_q   <= 1'b0;
         active_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         sclk_q   <= sclk_d;
         active_q <= active_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      sclk_d   = sclk_q;
      active_d = active_q;
      fifo_pop = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               // Loading the shift register also puts bit 15 on MOSI,
               // since MOSI is the register's MSB.
               fifo_pop = 1'b1;
               shreg_d  = fifo_head;
               active_d = 1'b0;
               div_d    = '0;
               bit_d    = '0;
               state_d  = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               sclk_d  = 1'b1;
               bit_d   = 5'd1;
               state_d = ST_SHIFT;
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         // SHIFT covers 32 half periods: 16 high phases, each followed by a
         // low phase. The low phase after the 16th rising edge completes the
         // last bit cell before HOLD begins.
         ST_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (sclk_q) begin
                  sclk_d = 1'b0;
                  // The final falling edge leaves MOSI on the last bit.
                  if (bit_q != BITS_LAST) begin
                     shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                  end
               end else if (bit_q == BITS_LAST) begin
                  state_d = ST_HOLD;
               end else begin
                  sclk_d = 1'b1;
                  bit_d  = bit_q + 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         ST_HOLD: begin
            if (div_q == DIV_LAST) begin
               div_d    = '0;
               active_d = 1'b1;
               state_d  = ST_GAP;
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         ST_GAP: begin
            if (div_q == GAP_LAST) begin
               div_d   = '0;
               bit_d   = '0;
               state_d = ST_IDLE;
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         default: begin
            state_d  = ST_IDLE;
            div_d    = '0;
            bit_d    = '0;
            sclk_d   = 1'b0;
            active_d = 1'b1;
         end
      endcase
   end

   assign audio_ready    = !fifo_full;
   assign com_sclk_out   = sclk_q;
   assign com_mosi_out   = shreg_q[WORD_W-1];
   assign com_active_out = active_q;
   assign busy           = (state_q != ST_IDLE);
   assign fsm_state      = state_q;

endmodule

// File: tb/tb_audio_spi_tx.sv
// ---------------------------------------------------------------------------
// tb_audio_spi_tx
// Bench for audio_spi_tx: a default-parameter instance (SCLK_DIV=4,
// CS_GAP=8) and a fast instance (SCLK_DIV=3, CS_GAP=2). Accepted words go
// into expected queues; a monitor decodes the serial frames at the pins and
// compares each decoded word, bit count, select-low time and MOSI stability.
// ---------------------------------------------------------------------------
module tb_audio_spi_tx;
   import audio_spi_pkg::*;

   localparam int DIV0 = 4;
   localparam int GAP0 = 8;
   localparam int DIV1 = 3;
   localparam int GAP1 = 2;
   // Select low: setup half period + 32 shift half periods + hold.
   localparam int LOW0    = DIV0 + 32 * DIV0 + DIV0;
   localparam int LOW1    = DIV1 + 32 * DIV1 + DIV1;
   // Frame-to-frame period adds the gap and one idle cycle.
   localparam int PERIOD0 = LOW0 + GAP0 + 1;
   localparam int PERIOD1 = LOW1 + GAP1 + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic rst, rst2;

   // ---------------- DUT 0 (defaults) ----------------
   logic [15:0] data;
   logic        valid;
   logic        ready, sclk, mosi, act, busy;
   logic [2:0]  level;
   logic [2:0]  state;

   audio_spi_tx #(.SCLK_DIV(DIV0), .CS_GAP(GAP0), .FIFO_DEPTH(4)) dut (
      .clk_25mhz      (clk),
      .reset          (rst),
      .audio_in       (data),
      .audio_valid    (valid),
      .audio_ready    (ready),
      .com_sclk_out   (sclk),
      .com_mosi_out   (mosi),
      .com_active_out (act),
      .busy           (busy),
      .fifo_level     (level),
      .fsm_state      (state)
   );

   // ---------------- DUT 1 (fast timing) ----------------
   logic [15:0] data2;
   logic        valid2;
   logic        ready2, sclk2, mosi2, act2, busy2;
   logic [2:0]  level2;
   logic [2:0]  state2;

   audio_spi_tx #(.SCLK_DIV(DIV1), .CS_GAP(GAP1), .FIFO_DEPTH(4)) dut2 (
      .clk_25mhz      (clk),
      .reset          (rst2),
      .audio_in       (data2),
      .audio_valid    (valid2),
      .audio_ready    (ready2),
      .com_sclk_out   (sclk2),
      .com_mosi_out   (mosi2),
      .com_active_out (act2),
      .busy           (busy2),
      .fifo_level     (level2),
      .fsm_state      (state2)
   );

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_q2[$];
   int          start_q[$];
   int          start_q2[$];
   bit          done2 = 1'b0;

   int          cyc[2];
   int          bits[2];
   int          low_cnt[2];
   int          viol[2];
   int          stray[2];
   logic        in_frame[2];
   logic        prev_sclk[2];
   logic        prev_mosi[2];
   logic        prev_cs[2];
   logic [15:0] word[2];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // ---------------- monitor ----------------
   task automatic mon_step(input int k, input logic sc, input logic mo, input logic cs, input logic rs);
      logic [15:0] e;
      bit          have;
      e    = '0;
      have = 1'b0;
      cyc[k]++;
      if (rs) begin
         in_frame[k] = 1'b0;
         bits[k]     = 0;
      end else begin
         if (prev_cs[k] === 1'b1 && cs === 1'b0) begin
            in_frame[k] = 1'b1;
            bits[k]     = 0;
            word[k]     = '0;
            low_cnt[k]  = 0;
            viol[k]     = 0;
            if (k == 0) start_q.push_back(cyc[k]);
            else        start_q2.push_back(cyc[k]);
         end else if (in_frame[k] && !cs && mo !== prev_mosi[k] && !(prev_sclk[k] && !sc)) begin
            viol[k]++;   // MOSI moved without a falling SCLK edge
         end
         if (!cs) low_cnt[k]++;
         if (sc !== prev_sclk[k]) begin
            if (cs) stray[k]++;
            else if (sc) begin
               bits[k]++;
               word[k] = {word[k][14:0], mo};
            end
         end
         if (prev_cs[k] === 1'b0 && cs === 1'b1 && in_frame[k]) begin
            in_frame[k] = 1'b0;
            chk($sformatf("frame_bits[%0d]", k), bits[k], 16);
            chk($sformatf("frame_low[%0d]", k), low_cnt[k], (k == 0) ? LOW0 : LOW1);
            chk($sformatf("frame_mosi_stable[%0d]", k), viol[k], 0);
            if (k == 0) begin
               have = (exp_q.size() != 0);
               if (have) e = exp_q.pop_front();
            end else begin
               have = (exp_q2.size() != 0);
               if (have) e = exp_q2.pop_front();
            end
            if (!have) begin
               checks++;
               errors++;
               $display("FAIL frame_word[%0d]: got %h with no word expected", k, word[k]);
            end else begin
               chk($sformatf("frame_word[%0d]", k), word[k], e);
            end
         end
      end
      prev_sclk[k] = sc;
      prev_mosi[k] = mo;
      prev_cs[k]   = cs;
   endtask

   always @(negedge clk) begin
      mon_step(0, sclk, mosi, act, rst);
      mon_step(1, sclk2, mosi2, act2, rst2);
   end

   // ---------------- driver tasks ----------------
   task automatic push0(input logic [15:0] d);
      int n;
      n = 0;
      @(negedge clk);
      valid = 1'b1;
      data  = d;
      while (!ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: word %h not accepted after %0d cycles", d, n);
         valid = 1'b0;
      end else begin
         exp_q.push_back(d);
         @(posedge clk);
         #1 valid = 1'b0;
      end
   endtask

   task automatic wait_idle0(input int max, input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk(name, (exp_q.size() != 0 || busy), 0);
   endtask

   // ---------------- main sequence (DUT 0) ----------------
   initial begin
      int   fall_at;
      bit   seen;
      int   n;
      int   acc;
      rst   = 1'b1;
      valid = 1'b0;
      data  = '0;
      repeat (3) @(negedge clk);
      chk("reset_sclk", sclk, 0);
      chk("reset_mosi", mosi, 0);
      chk("reset_active", act, 1);
      chk("reset_busy", busy, 0);
      chk("reset_ready", ready, 1);
      chk("reset_level", level, 0);
      chk("reset_state", state, ST_IDLE);
      rst = 1'b0;

      // Single word: bit-exact frame, busy drops 145 cycles after the push edge.
      push0(16'hA5C3);
      fall_at = -1;
      seen    = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (fall_at < 0) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            else if (seen) fall_at = i;
         end
      end
      chk("busy_seen", seen, 1);
      chk("busy_low_after_push", fall_at, PERIOD0);
      wait_idle0(300, "single_done_timeout");

      // Six back-to-back words: back-pressure at level 4, order, spacing.
      start_q.delete();
      for (int w = 1; w <= 5; w++) push0(16'(w));
      @(negedge clk);
      chk("full_level", level, 4);
      chk("full_ready", ready, 0);
      push0(16'h0006);
      wait_idle0(6 * PERIOD0 + 200, "burst_done_timeout");
      chk("burst_frames", start_q.size(), 6);
      if (start_q.size() == 6) begin
         for (int i = 1; i < 6; i++)
            chk($sformatf("burst_period[%0d]", i), start_q[i] - start_q[i-1], PERIOD0);
      end

      // Reset after the 7th rising SCLK edge of an all-ones word.
      push0(16'hFFFF);
      n = 0;
      while (!(in_frame[0] && bits[0] == 7) && n < 400) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk("reset_wait_timeout", (in_frame[0] && bits[0] == 7), 1);
      rst = 1'b1;
      #1;
      chk("abort_active", act, 1);
      chk("abort_sclk", sclk, 0);
      chk("abort_level", level, 0);
      chk("abort_ready", ready, 1);
      chk("abort_busy", busy, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push0(16'h0000);
      wait_idle0(300, "after_reset_timeout");

      // Random words with random valid; pushes while full must be dropped.
      acc = 0;
      n   = 0;
      while (acc < 40 && n < 40 * PERIOD0 * 3) begin
         @(negedge clk);
         n++;
         valid = ($urandom_range(0, 3) == 0);
         data  = 16'($urandom);
         if (valid && ready) begin
            exp_q.push_back(data);
            acc++;
         end
      end
      @(posedge clk);
      #1 valid = 1'b0;
      chk("random_accepted", acc, 40);
      wait_idle0(6 * PERIOD0 + 200, "random_done_timeout");

      n = 0;
      while (!done2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("fast_done_timeout", done2, 1);
      chk("stray_edges[0]", stray[0], 0);
      chk("stray_edges[1]", stray[1], 0);
      chk("leftover[0]", exp_q.size(), 0);
      chk("leftover[1]", exp_q2.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // ---------------- fast instance (DUT 1) ----------------
   initial begin
      int n;
      rst2   = 1'b1;
      valid2 = 1'b0;
      data2  = '0;
      repeat (3) @(negedge clk);
      chk("fast_reset_state", state2, ST_IDLE);
      chk("fast_reset_level", level2, 0);
      rst2 = 1'b0;

      @(negedge clk);
      valid2 = 1'b1;
      data2  = 16'h8000;
      chk("fast_ready0", ready2, 1);
      exp_q2.push_back(16'h8000);
      @(negedge clk);
      data2 = 16'h7FFF;
      chk("fast_ready1", ready2, 1);
      exp_q2.push_back(16'h7FFF);
      @(posedge clk);
      #1 valid2 = 1'b0;

      n = 0;
      while ((exp_q2.size() != 0 || busy2) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("fast_done", (exp_q2.size() != 0 || busy2), 0);
      chk("fast_frames", start_q2.size(), 2);
      if (start_q2.size() == 2)
         chk("fast_period", start_q2[1] - start_q2[0], PERIOD1);
      done2 = 1'b1;
   end

endmodule

// File: doc/audio_spi_tx.md
AUDIO_SPI_TX -- requirements
Module: audio_spi_tx

Interface
REQ-001 Parameter SCLK_DIV, default 4: clk_25mhz cycles per SCLK half-period; the block SHALL reject SCLK_DIV < 3 at elaboration, since the receiver uses a 2-FF SCLK synchroniser.
REQ-002 Parameter CS_GAP, default 8: clk_25mhz cycles com_active_out SHALL stay high between frames; the block SHALL reject values < 2.
REQ-003 Parameter FIFO_DEPTH, default 4: word FIFO depth, SHALL be a power of 2.
REQ-004 clk_25mhz  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 audio_in  in  16  sample word to transmit.
REQ-007 audio_valid  in  1  audio_in presented this cycle.
REQ-008 audio_ready  out  1  FIFO not full; a word SHALL be accepted on cycles where audio_valid && audio_ready.
REQ-009 com_sclk_out  out  1  serial clock to the Pico; idle low.
REQ-010 com_mosi_out  out  1  serial data, MSB first.
REQ-011 com_active_out  out  1  frame select, active low; high when idle.
REQ-012 busy  out  1  high from frame start through the end of the CS_GAP phase.
REQ-013 fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-015 IDLE: if the FIFO is non-empty, the block SHALL pop the head word into a 16-bit shift register, go to SETUP, drive com_active_out low and drive com_mosi_out with bit 15, all on the same edge.
REQ-016 SETUP: SCLK SHALL stay low for SCLK_DIV cycles, then the FSM SHALL go to SHIFT.
REQ-017 SHIFT: SCLK SHALL toggle every SCLK_DIV cycles, starting with a rising edge.
REQ-018 MOSI SHALL change only on SCLK falling edges (next lower bit) and SHALL be stable across each rising edge.
REQ-019 A bit counter SHALL count rising edges; after the 16th high phase, SCLK SHALL fall and the FSM SHALL go to HOLD with MOSI unchanged.
REQ-020 HOLD: com_active_out SHALL stay low for SCLK_DIV cycles, then go high and the FSM SHALL go to GAP.
REQ-021 GAP: com_active_out SHALL stay high for CS_GAP cycles, then the FSM SHALL go to IDLE; a pending word SHALL start its frame on the following edge.
REQ-022 Frame period with defaults SHALL be exactly 4+128+4+8+1 = 145 cycles between successive com_active_out falling edges.
REQ-023 Exactly 16 rising SCLK edges SHALL occur per frame; no SCLK edge SHALL occur while com_active_out is high.
REQ-024 audio_ready SHALL equal (fifo_level != FIFO_DEPTH), derived from registered state only.
REQ-025 Push with a simultaneous pop SHALL leave fifo_level unchanged and preserve word order.
REQ-026 Push while full SHALL be ignored with no FIFO change.
REQ-027 Pop while empty SHALL never occur.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 Words SHALL be transmitted in acceptance order, bit-exact.
REQ-030 The FSM SHALL not return to IDLE mid-frame except via reset; the FIFO SHALL be the only back-pressure, and the block SHALL have no underrun condition.

Reset
REQ-031 While reset is high: FSM = IDLE, FIFO emptied (fifo_level = 0), com_sclk_out = 0, com_mosi_out = 0, com_active_out = 1, busy = 0, audio_ready = 1, bit counter and divider = 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously); the partial word SHALL be discarded.
REQ-033 After release, the first frame SHALL be a complete 16-bit frame of the next accepted word.

Structure
REQ-034 Shared package audio_spi_pkg SHALL hold the FSM state codes as localparam logic [2:0] constants (no enum), WORD_W = 16 and default SCLK_DIV/CS_GAP.
REQ-035 The FIFO SHALL be a separate sub-module spi_tx_fifo (synchronous, single clock, registered level); serialiser/FSM logic SHALL stay in audio_spi_tx.

Verification
REQ-036 Push 16'hA5C3 once -> com_active_out low for 136 cycles; MOSI at the 16 rising edges = 1010_0101_1100_0011; busy low 145 cycles after the push edge.
REQ-037 Push 6 words on consecutive cycles (16'h0001..16'h0006) -> audio_ready drops when fifo_level = 4, and the 6th word is held until accepted; frames 0001..0006 are transmitted in order, 145 cycles apart.
REQ-038 Loopback into the existing receiver top (com_* wired across) with 200 random words -> audio_out sequence identical and exactly 200 data_ready pulses.
REQ-039 Assert reset after the 7th rising SCLK edge of 16'hFFFF -> same-cycle com_active_out = 1, SCLK = 0, fifo_level = 0; then push 16'h0000 -> 16 zero bits are received with no residual bits.
REQ-040 SCLK_DIV = 3, CS_GAP = 2 with back-to-back 16'h8000/16'h7FFF -> 16 rising edges each, MSB sampled correctly, frame period 3+96+3+2+1 = 105 cycles.
